memcpy_job_scheduler: RTL and testbench

Sequences memory-copy jobs from two independent requesters onto the single shared memcpy engine. Each requester issues descriptors (source, target, byte length, tag) over a valid/ready handshake. The scheduler arbitrates round-robin, drives the engine's parameter/start/done interface one job at a time, and reports per-job completion with tag and error status. It sits between the action's control/register logic and the memcpy engine.

---
 rtl/memcpy_sched_pkg.sv | 7 +
 rtl/rr_arbiter2.sv | 18 +
 rtl/memcpy_job_scheduler.sv | 104 ++++++++++
 tb/tb_memcpy_job_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/memcpy_sched_pkg.sv
// memcpy_sched_pkg: shared types and widths for the memcpy job scheduler.
package memcpy_sched_pkg;
  localparam int TAG_W = 8;
  localparam int LEN_W = 64;
  localparam int NREQ  = 2;
  typedef enum logic [2:0] {S_IDLE, S_START, S_GUARD, S_WAIT, S_CPL, S_HALT} state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin; last grant moves only on acceptance.
module rr_arbiter2
  import memcpy_sched_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_accept,
  output logic [NREQ-1:0] o_gnt
);
  logic r_last;
  // Reset to 1 so requester 0 wins the first contention.
  assign o_gnt = &i_req ? (r_last ? 2'b01 : 2'b10) : i_req;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_last <= 1'b1;
    else if (i_accept) r_last <= o_gnt[1];
  end
endmodule

// File: rtl/memcpy_job_scheduler.sv
// memcpy_job_scheduler: round-robin sequencing of two requesters' copy jobs
// onto one memcpy engine, with per-job completion and timeout-to-halt.
module memcpy_job_scheduler
  import memcpy_sched_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 64,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1048576
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [2*ADDR_WIDTH-1:0] req_src,
  input  logic [2*ADDR_WIDTH-1:0] req_tgt,
  input  logic [2*LEN_W-1:0]      req_len,
  input  logic [2*TAG_W-1:0]      req_tag,
  output logic [ADDR_WIDTH-1:0]   memcpy_src_addr,
  output logic [ADDR_WIDTH-1:0]   memcpy_tgt_addr,
  output logic [LEN_W-1:0]        memcpy_len,
  output logic                    memcpy_start,
  input  logic                    memcpy_done,
  output logic                    cpl_valid,
  output logic                    cpl_req,
  output logic [TAG_W-1:0]        cpl_tag,
  output logic                    cpl_err,
  output logic                    busy,
  output logic [31:0]             jobs_done
);
  state_t                r_state, w_next;
  logic [NREQ-1:0]       w_gnt;
  logic                  w_accept, w_sel, w_zero, w_to;
  logic [LEN_W-1:0]      w_len;
  logic [31:0]           r_cnt, r_jobs;
  logic [ADDR_WIDTH-1:0] r_src, r_tgt;
  logic [LEN_W-1:0]      r_len;
  logic [TAG_W-1:0]      r_tag;
  logic                  r_req, r_err, r_start, r_cpl, r_busy;

  rr_arbiter2 u_arb (.clk(clk), .rst_n(rst_n), .i_req(req_valid), .i_accept(w_accept), .o_gnt(w_gnt));

  assign w_accept  = r_state == S_IDLE && |req_valid;
  assign req_ready = r_state == S_IDLE ? w_gnt : '0;
  assign w_sel     = w_gnt[1];
  assign w_len     = w_sel ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
  assign w_zero    = w_len == '0;
  assign w_to      = r_cnt == TIMEOUT_CYCLES - 1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_zero ? S_CPL : S_START;
      S_START: w_next = S_GUARD;
      // GUARD exists because the previous job's done level may still be high.
      S_GUARD: w_next = S_WAIT;
      S_WAIT:  if (memcpy_done || w_to) w_next = S_CPL;
      S_CPL:   w_next = r_err ? S_HALT : S_IDLE;
      default: w_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_jobs  <= '0;
      r_src   <= '0;
      r_tgt   <= '0;
      r_len   <= '0;
      r_tag   <= '0;
      r_req   <= 1'b0;
      r_err   <= 1'b0;
      r_start <= 1'b0;
      r_cpl   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_start <= w_next == S_START;
      r_cpl   <= w_next == S_CPL;
      r_busy  <= w_next != S_IDLE;
      r_cnt   <= r_state == S_WAIT ? r_cnt + 1 : '0;
      if (w_accept) begin
        r_src <= w_sel ? req_src[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_src[ADDR_WIDTH-1:0];
        r_tgt <= w_sel ? req_tgt[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_tgt[ADDR_WIDTH-1:0];
        r_len <= w_len;
        r_tag <= w_sel ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
        r_req <= w_sel;
        r_err <= 1'b0;
      end
      if (r_state == S_WAIT && w_next == S_CPL) r_err <= !memcpy_done;
      if (r_state == S_CPL && !r_err) r_jobs <= r_jobs + 1;
    end
  end

  assign memcpy_src_addr = r_src;
  assign memcpy_tgt_addr = r_tgt;
  assign memcpy_len      = r_len;
  assign memcpy_start    = r_start;
  assign cpl_valid       = r_cpl;
  assign cpl_req         = r_req;
  assign cpl_tag         = r_tag;
  assign cpl_err         = r_err;
  assign busy            = r_busy;
  assign jobs_done       = r_jobs;
endmodule

// File: tb/tb_memcpy_job_scheduler.sv
// tb_memcpy_job_scheduler: randomized jobs against a queue-based model of the
// scheduler plus a behavioural memcpy engine.
module tb_memcpy_job_scheduler;
  localparam int AW = 64;
  localparam int TO = 64;

  typedef struct {logic [63:0] src, tgt, len; logic [7:0] tag;} desc_t;
  typedef struct {logic r; logic [7:0] tag; logic err; logic zero; logic [63:0] len;} cpl_t;

  logic clk = 0, rst_n = 0;
  logic [1:0] req_valid = '0, req_ready;
  logic [2*AW-1:0] req_src = '0, req_tgt = '0;
  logic [127:0] req_len = '0;
  logic [15:0] req_tag = '0;
  logic [AW-1:0] memcpy_src_addr, memcpy_tgt_addr;
  logic [63:0] memcpy_len;
  logic memcpy_start, memcpy_done, cpl_valid, cpl_req, cpl_err, busy;
  logic [7:0] cpl_tag;
  logic [31:0] jobs_done;

  memcpy_job_scheduler #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_tgt(req_tgt), .req_len(req_len), .req_tag(req_tag),
    .memcpy_src_addr(memcpy_src_addr), .memcpy_tgt_addr(memcpy_tgt_addr),
    .memcpy_len(memcpy_len), .memcpy_start(memcpy_start), .memcpy_done(memcpy_done),
    .cpl_valid(cpl_valid), .cpl_req(cpl_req), .cpl_tag(cpl_tag), .cpl_err(cpl_err),
    .busy(busy), .jobs_done(jobs_done));

  always #5 clk = ~clk;

  // Engine model: done is a level that drops on start (unless stale) and rises after a delay.
  bit e_stale = 0, e_never = 0, e_act;
  int e_fixed = 0, e_lim, e_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memcpy_done <= 1'b0; e_act <= 0; e_cnt <= 0; e_lim <= 1;
    end else if (memcpy_start) begin
      e_act <= 1; e_cnt <= 1;
      e_lim <= e_fixed > 0 ? e_fixed : int'($urandom_range(12, 1));
      if (!e_stale) memcpy_done <= 1'b0;
    end else if (e_act) begin
      e_cnt <= e_cnt + 1;
      if (!e_never && e_cnt >= e_lim) begin memcpy_done <= 1'b1; e_act <= 0; end
      else memcpy_done <= 1'b0;
    end
  end

  int errors = 0, checks = 0;
  desc_t q0[$], q1[$], exp_st[$];
  cpl_t expc[$];
  int cyc = 0, acc_cyc = 0, st_cyc = -1, first_done = -1, model_jobs = 0;
  bit inflight = 0, halted = 0;
  logic model_last = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] pick(input logic [1:0] v, input logic last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  task automatic push(input int r, input logic [63:0] src, tgt, len, input logic [7:0] tag);
    desc_t d;
    d.src = src; d.tgt = tgt; d.len = len; d.tag = tag;
    if (r == 0) q0.push_back(d); else q1.push_back(d);
  endtask

  task automatic push_rand(input int r, input bit allow_zero);
    logic [63:0] len;
    len = (allow_zero && $urandom_range(3, 0) == 0) ? 64'd0 : {32'($urandom), 32'($urandom_range(4096, 1))};
    push(r, {$urandom, $urandom}, {$urandom, $urandom}, len, 8'($urandom));
  endtask

  task automatic check_reset();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_src", memcpy_src_addr, 0);
    chk("rst_tgt", memcpy_tgt_addr, 0);
    chk("rst_len", memcpy_len, 0);
    chk("rst_start", memcpy_start, 0);
    chk("rst_cpl_valid", cpl_valid, 0);
    chk("rst_cpl_req", cpl_req, 0);
    chk("rst_cpl_tag", cpl_tag, 0);
    chk("rst_cpl_err", cpl_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_jobs_done", jobs_done, 0);
  endtask

  task automatic run(input int ncyc, input bit until_empty);
    desc_t d;
    cpl_t e;
    logic [1:0] g;
    bit clr;
    for (int k = 0; k < ncyc; k++) begin
      if (until_empty && q0.size() == 0 && q1.size() == 0 && !inflight) break;
      @(negedge clk);
      cyc++;
      clr = 0;
      if (exp_st.size() == 0) chk("start_unexpected", memcpy_start, 0);
      else if (memcpy_start) begin
        d = exp_st.pop_front();
        chk("start_src", memcpy_src_addr, d.src);
        chk("start_tgt", memcpy_tgt_addr, d.tgt);
        chk("start_len", memcpy_len, d.len);
        chk("start_latency", cyc - acc_cyc, 1);
        st_cyc = cyc; first_done = -1;
      end
      if (inflight && st_cyc >= 0 && cyc >= st_cyc + 2 && memcpy_done && first_done < 0) first_done = cyc;
      if (expc.size() == 0) chk("cpl_unexpected", cpl_valid, 0);
      else if (cpl_valid) begin
        e = expc.pop_front();
        chk("cpl_req", cpl_req, e.r);
        chk("cpl_tag", cpl_tag, e.tag);
        chk("cpl_err", cpl_err, e.err);
        chk("cpl_jobs_done", jobs_done, model_jobs);
        if (e.zero) chk("cpl_zero_latency", cyc - acc_cyc, 1);
        else begin
          chk("cpl_len_held", memcpy_len, e.len);
          if (e.err) chk("cpl_timeout_latency", cyc - st_cyc, TO + 2);
          else chk("cpl_done_latency", cyc - first_done, 1);
        end
        if (e.err) halted = 1; else model_jobs++;
        clr = 1;
      end
      chk("busy", busy, inflight || halted);
      req_valid = {q1.size() != 0, q0.size() != 0};
      if (q0.size() != 0) begin
        req_src[AW-1:0] = q0[0].src; req_tgt[AW-1:0] = q0[0].tgt;
        req_len[63:0] = q0[0].len; req_tag[7:0] = q0[0].tag;
      end
      if (q1.size() != 0) begin
        req_src[2*AW-1:AW] = q1[0].src; req_tgt[2*AW-1:AW] = q1[0].tgt;
        req_len[127:64] = q1[0].len; req_tag[15:8] = q1[0].tag;
      end
      #1;
      g = (inflight || halted) ? 2'b00 : pick(req_valid, model_last);
      chk("req_ready", req_ready, g);
      if (clr) inflight = 0;
      if (g != 2'b00) begin
        d = g[1] ? q1.pop_front() : q0.pop_front();
        model_last = g[1];
        e.r = g[1]; e.tag = d.tag; e.zero = d.len == 0; e.len = d.len;
        e.err = !e.zero && e_never;
        expc.push_back(e);
        if (!e.zero) exp_st.push_back(d);
        acc_cyc = cyc; st_cyc = -1; first_done = -1; inflight = 1;
      end
    end
    if (until_empty) chk("drain", q0.size() + q1.size() + expc.size() + int'(inflight), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset();
    rst_n = 1;
    // Single job from requester 0, engine done 20 cycles after start.
    e_fixed = 20;
    push(0, 64'h1000, 64'h2000, 64'd256, 8'h11);
    run(200, 1); run(1, 0);
    chk("jobs_after_single", jobs_done, 1);
    // Both requesters continuously valid: grants alternate.
    e_fixed = 0;
    for (int i = 0; i < 4; i++) begin push_rand(0, 0); push_rand(1, 0); end
    run(1000, 1); run(1, 0);
    chk("jobs_after_alternate", jobs_done, 9);
    // Stale done level from the previous job spans the start/guard cycles.
    e_stale = 1; e_fixed = 5;
    push_rand(0, 0);
    run(200, 1); run(1, 0);
    e_stale = 0; e_fixed = 0;
    // Zero-length job from requester 1.
    push(1, 64'h5000, 64'h6000, 64'd0, 8'h7F);
    run(50, 1); run(1, 0);
    chk("jobs_after_zero", jobs_done, 11);
    // Random mix including zero-length jobs.
    for (int i = 0; i < 14; i++) push_rand(int'($urandom_range(1, 0)), 1);
    run(2000, 1); run(1, 0);
    chk("jobs_after_random", jobs_done, model_jobs);
    // Reset pulsed while the engine is being waited on.
    e_fixed = 40;
    push_rand(1, 0);
    run(8, 0);
    @(negedge clk);
    req_valid = '0; rst_n = 0;
    #1;
    check_reset();
    q0.delete(); q1.delete(); exp_st.delete(); expc.delete();
    inflight = 0; halted = 0; model_last = 1'b1; model_jobs = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    e_fixed = 0;
    push_rand(1, 0); push_rand(0, 0);
    run(500, 1); run(1, 0);
    chk("jobs_after_reset", jobs_done, 2);
    // Engine never finishes: timeout then halt.
    e_never = 1;
    push_rand(0, 0);
    run(300, 1); run(1, 0);
    chk("jobs_after_timeout", jobs_done, 2);
    push_rand(1, 0);
    run(10, 0);
    chk("halt_busy", busy, 1);
    chk("halt_jobs", jobs_done, model_jobs);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
